// File: rtl/urv_dmem_bridge.sv
// Data-memory bridge: one pipelined-Wishbone transaction at a time for execute-stage loads/stores.
// Optional bus timeout enabled by defining URV_DMEM_TIMEOUT_EN.
module urv_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_busy_o,
    output logic        dm_bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        busy_q, busy_d;
    logic [31:0] data_l_q, data_l_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;
    logic        bus_err_q, bus_err_d;
    logic        finish;
    logic        fail;
    logic        timeout;

`ifdef URV_DMEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter holds k-1 during the k-th busy cycle, so the last allowed cycle ends the transaction.
    assign timeout = (state_q != S_IDLE) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    // The timeout length has no effect when the counter is not built.
    logic unused_cfg;
    assign unused_cfg = ^16'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        busy_d       = busy_q;
        data_l_d     = data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        bus_err_d    = 1'b0;
        finish       = 1'b0;
        fail         = 1'b0;
`ifdef URV_DMEM_TIMEOUT_EN
        cnt_d        = cnt_q + 16'd1;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef URV_DMEM_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (dm_store_i || dm_load_i) begin
                    adr_d   = {dm_addr_i[31:2], 2'b00};
                    sel_d   = dm_data_select_i;
                    we_d    = dm_store_i;
                    // A simultaneous load is dropped in favour of the store.
                    if (dm_store_i) dat_d = dm_data_s_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = S_WAIT;
                    finish  = wb_ack_i | wb_err_i;
                end
                finish = finish | timeout;
            end
            S_WAIT: begin
                finish = wb_ack_i | wb_err_i | timeout;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            fail      = wb_err_i | timeout;
            state_d   = S_IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            busy_d    = 1'b0;
            bus_err_d = fail;
            if (we_q) begin
                store_done_d = 1'b1;
            end else begin
                load_done_d = 1'b1;
                data_l_d    = fail ? 32'd0 : wb_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_l_q     <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            busy_q       <= busy_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_busy_o       = busy_q;
    assign dm_bus_err_o    = bus_err_q;
    assign wb_adr_o        = adr_q;
    assign wb_dat_o        = dat_q;
    assign wb_sel_o        = sel_q;
    assign wb_we_o         = we_q;
    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = stb_q;

endmodule
